// File: rtl/regfile_mp_sb_if.sv
// Bus bundle between the decode/write-back stages and the register file.
// Carries the packed read ports, both write-back ports and the issue strobe.
interface regfile_mp_sb_if #(
  parameter int XLEN   = 64,
  parameter int NREGS  = 32,
  parameter int NUM_RD = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NUM_RD*AW-1:0]   rd_addr;
  logic [NUM_RD*XLEN-1:0] rd_data;
  logic [NUM_RD-1:0]      rd_pend;

  logic                   wr0_en;
  logic [AW-1:0]          wr0_addr;
  logic [XLEN-1:0]        wr0_data;

  logic                   wr1_en;
  logic [AW-1:0]          wr1_addr;
  logic [XLEN-1:0]        wr1_data;

  logic                   iss_en;
  logic [AW-1:0]          iss_rd;

  // Pipeline side: presents addresses, write-backs and issues.
  modport master (
    output rd_addr, wr0_en, wr0_addr, wr0_data,
    output wr1_en, wr1_addr, wr1_data, iss_en, iss_rd,
    input  rd_data, rd_pend
  );

  // Register-file side.
  modport slave (
    input  rd_addr, wr0_en, wr0_addr, wr0_data,
    input  wr1_en, wr1_addr, wr1_data, iss_en, iss_rd,
    output rd_data, rd_pend
  );
endinterface

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with two prioritised write-back ports,
// same-cycle write-to-read bypass, a per-register pending scoreboard and a
// post-reset sweep that zeroes every architectural register.
module regfile_mp_sb #(
  parameter int XLEN   = 64,
  parameter int NREGS  = 32,
  parameter int NUM_RD = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             init_done,
  regfile_mp_sb_if.slave   bus
);
  localparam int AW = $clog2(NREGS);

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state, state_nx;
  logic [AW-1:0]     idx, idx_nx;
  logic [XLEN-1:0]   mem [NREGS];
  logic [NREGS-1:0]  pend, pend_nx;
  logic [AW-1:0]     ra [NUM_RD];

  logic ready;
  logic wr0_ok, wr1_ok, iss_ok;

  assign ready     = (state == READY);
  assign init_done = ready;

  // Writes and issues only take effect once the sweep is done; x0 is never a target.
  assign wr0_ok = ready && bus.wr0_en && (bus.wr0_addr != '0);
  assign wr1_ok = ready && bus.wr1_en && (bus.wr1_addr != '0);
  assign iss_ok = ready && bus.iss_en && (bus.iss_rd   != '0);

  for (genvar k = 0; k < NUM_RD; k++) begin : g_ra
    assign ra[k] = bus.rd_addr[k*AW +: AW];
  end

  // Sweep FSM state and index registers.
  // NOTE: control state sits on the async reset; the storage array below does not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      idx   <= AW'(1);
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  // Sweep next-state: step the index each cycle, finish on the last register.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    if (state == CLEAR) begin
      idx_nx = idx + AW'(1);
      if (idx == AW'(NREGS - 1)) state_nx = READY;
    end
  end

  // Register array: zeroed by the sweep, then written by the two write-back ports.
  // NOTE: no reset on the array -- the sweep clears it, keeping it RAM-friendly.
  // wr1 is written last so it wins a same-address collision with wr0.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[idx] <= '0;
    end else begin
      if (wr0_ok) mem[bus.wr0_addr] <= bus.wr0_data;
      if (wr1_ok) mem[bus.wr1_addr] <= bus.wr1_data;
    end
  end

  // Scoreboard next value: retiring writes clear, a new issue sets (set wins).
  always_comb begin
    pend_nx = pend;
    if (wr0_ok) pend_nx[bus.wr0_addr] = 1'b0;
    if (wr1_ok) pend_nx[bus.wr1_addr] = 1'b0;
    if (iss_ok) pend_nx[bus.iss_rd]   = 1'b1;
    pend_nx[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend <= '0;
    else        pend <= pend_nx;
  end

  // Read ports: x0 -> 0, then wr1 bypass, then wr0 bypass, then the array.
  always_comb begin
    bus.rd_data = '0;
    bus.rd_pend = '0;
    if (ready) begin
      for (int k = 0; k < NUM_RD; k++) begin
        if (ra[k] == '0) begin
          bus.rd_data[k*XLEN +: XLEN] = '0;
        end else if (wr1_ok && (bus.wr1_addr == ra[k])) begin
          bus.rd_data[k*XLEN +: XLEN] = bus.wr1_data;
        end else if (wr0_ok && (bus.wr0_addr == ra[k])) begin
          bus.rd_data[k*XLEN +: XLEN] = bus.wr0_data;
        end else begin
          bus.rd_data[k*XLEN +: XLEN] = mem[ra[k]];
        end
        // Forwarded data is final, so it is never flagged pending.
        bus.rd_pend[k] = pend[ra[k]] &&
                         !(wr1_ok && (bus.wr1_addr == ra[k])) &&
                         !(wr0_ok && (bus.wr0_addr == ra[k]));
      end
    end
  end
endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench driving two register files in lockstep: the default
// configuration and a narrow XLEN=32/NREGS=16/NUM_RD=3 variant.
module tb_regfile_mp_sb;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [4:0]  ra0, ra1, wr0_addr, wr1_addr, iss_rd;
  logic        wr0_en, wr1_en, iss_en;
  logic [63:0] wr0_data, wr1_data;
  logic        a_init, b_init;

  int tests = 0;
  int fails = 0;

  regfile_mp_sb_if #(.XLEN(64), .NREGS(32), .NUM_RD(2)) a_if ();
  regfile_mp_sb_if #(.XLEN(32), .NREGS(16), .NUM_RD(3)) b_if ();

  regfile_mp_sb #(.XLEN(64), .NREGS(32), .NUM_RD(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .init_done(a_init), .bus(a_if));
  regfile_mp_sb #(.XLEN(32), .NREGS(16), .NUM_RD(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .init_done(b_init), .bus(b_if));

  assign a_if.rd_addr  = {ra1, ra0};
  assign a_if.wr0_en   = wr0_en;
  assign a_if.wr0_addr = wr0_addr;
  assign a_if.wr0_data = wr0_data;
  assign a_if.wr1_en   = wr1_en;
  assign a_if.wr1_addr = wr1_addr;
  assign a_if.wr1_data = wr1_data;
  assign a_if.iss_en   = iss_en;
  assign a_if.iss_rd   = iss_rd;

  assign b_if.rd_addr  = {ra1[3:0], ra1[3:0], ra0[3:0]};
  assign b_if.wr0_en   = wr0_en;
  assign b_if.wr0_addr = wr0_addr[3:0];
  assign b_if.wr0_data = wr0_data[31:0];
  assign b_if.wr1_en   = wr1_en;
  assign b_if.wr1_addr = wr1_addr[3:0];
  assign b_if.wr1_data = wr1_data[31:0];
  assign b_if.iss_en   = iss_en;
  assign b_if.iss_rd   = iss_rd[3:0];

  logic [63:0] a_rd0, a_rd1;
  logic [31:0] b_rd0, b_rd1, b_rd2;
  assign a_rd0 = a_if.rd_data[63:0];
  assign a_rd1 = a_if.rd_data[127:64];
  assign b_rd0 = b_if.rd_data[31:0];
  assign b_rd1 = b_if.rd_data[63:32];
  assign b_rd2 = b_if.rd_data[95:64];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr0_en = 0; wr0_addr = 0; wr0_data = 0;
    wr1_en = 0; wr1_addr = 0; wr1_data = 0;
    iss_en = 0; iss_rd = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; idle(); ra0 = 0; ra1 = 0;
    #2;
    tests++;
    if (a_init !== 1'b0 || b_init !== 1'b0) begin
      fails++; $display("FAIL reset_init_done got a=%b b=%b want 0/0", a_init, b_init);
    end
    tests++;
    if (a_if.rd_pend !== 2'b00 || b_if.rd_pend !== 3'b000) begin
      fails++; $display("FAIL reset_rd_pend got a=%b b=%b want 0", a_if.rd_pend, b_if.rd_pend);
    end
  endtask

  task automatic test_sweep();
    int first_a = 0, first_b = 0, bad_a = 0, bad_b = 0;
    rst_n = 0; idle();
    repeat (3) tick();
    for (int i = 0; i < 32; i++) dut_a.mem[i] = 64'hDEAD;
    for (int i = 0; i < 16; i++) dut_b.mem[i] = 32'hDEAD;
    ra0 = 5'd31; ra1 = 5'd31;
    rst_n = 1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (a_init && first_a == 0) first_a = n;
      if (b_init && first_b == 0) first_b = n;
      if (!a_init && (a_if.rd_data !== '0)) bad_a++;
      if (!b_init && (b_if.rd_data !== '0)) bad_b++;
    end
    tests++;
    if (first_a !== 31) begin
      fails++; $display("FAIL sweep_len_a got %0d want 31", first_a);
    end
    tests++;
    if (first_b !== 15) begin
      fails++; $display("FAIL sweep_len_b got %0d want 15", first_b);
    end
    tests++;
    if (bad_a != 0 || bad_b != 0) begin
      fails++; $display("FAIL sweep_rd_zero nonzero reads a=%0d b=%0d want 0", bad_a, bad_b);
    end
    bad_a = 0; bad_b = 0;
    for (int i = 0; i < 32; i++) begin
      ra0 = 5'(i); ra1 = 5'(i);
      #1;
      if (a_rd0 !== 64'd0 || a_rd1 !== 64'd0) bad_a++;
      if (b_rd0 !== 32'd0 || b_rd1 !== 32'd0 || b_rd2 !== 32'd0) bad_b++;
    end
    tests++;
    if (bad_a != 0 || bad_b != 0) begin
      fails++; $display("FAIL sweep_cleared nonzero regs a=%0d b=%0d want 0", bad_a, bad_b);
    end
  endtask

  task automatic test_write_read();
    idle();
    wr0_en = 1; wr0_addr = 5; wr0_data = 64'h0000_0000_0000_1234;
    wr1_en = 1; wr1_addr = 6; wr1_data = 64'h0000_0000_0000_0ABC;
    tick(); idle();
    ra0 = 5; ra1 = 6;
    #1;
    tests++;
    if (a_rd0 !== 64'h1234 || b_rd0 !== 32'h1234) begin
      fails++; $display("FAIL wr_x5 got a=%h b=%h want 1234", a_rd0, b_rd0);
    end
    tests++;
    if (a_rd1 !== 64'hABC || b_rd1 !== 32'hABC) begin
      fails++; $display("FAIL wr_x6 got a=%h b=%h want abc", a_rd1, b_rd1);
    end
    wr0_en = 1; wr0_addr = 0; wr0_data = '1;
    ra0 = 0;
    #1;
    tests++;
    if (a_rd0 !== 64'd0 || b_rd0 !== 32'd0) begin
      fails++; $display("FAIL x0_bypass got a=%h b=%h want 0", a_rd0, b_rd0);
    end
    tick(); idle();
    #1;
    tests++;
    if (a_rd0 !== 64'd0 || b_rd0 !== 32'd0) begin
      fails++; $display("FAIL x0_write got a=%h b=%h want 0", a_rd0, b_rd0);
    end
    wr1_en = 1; wr1_addr = 7; wr1_data = 64'hFFFF_FFFF_FFFF_FFFF;
    tick(); idle();
    ra0 = 7;
    #1;
    tests++;
    if ($signed(a_rd0) != -64'sd1 || $signed(b_rd0) != -32'sd1) begin
      fails++; $display("FAIL x7_neg got a=%0d b=%0d want -1", $signed(a_rd0), $signed(b_rd0));
    end
  endtask

  task automatic test_bypass();
    idle();
    wr0_en = 1; wr0_addr = 9; wr0_data = 64'h11;
    wr1_en = 1; wr1_addr = 9; wr1_data = 64'h22;
    ra0 = 9; ra1 = 9;
    #1;
    tests++;
    if (a_rd0 !== 64'h22 || a_rd1 !== 64'h22) begin
      fails++; $display("FAIL byp_prio_a got p0=%h p1=%h want 22", a_rd0, a_rd1);
    end
    tests++;
    if (b_rd0 !== 32'h22 || b_rd1 !== 32'h22 || b_rd2 !== 32'h22) begin
      fails++; $display("FAIL byp_prio_b got p0=%h p1=%h p2=%h want 22", b_rd0, b_rd1, b_rd2);
    end
    tick(); idle();
    #1;
    tests++;
    if (a_rd0 !== 64'h22 || b_rd0 !== 32'h22) begin
      fails++; $display("FAIL byp_stored got a=%h b=%h want 22", a_rd0, b_rd0);
    end
    wr0_en = 1; wr0_addr = 9; wr0_data = 64'h33;
    ra0 = 5; ra1 = 9;
    #1;
    tests++;
    if (a_rd1 !== 64'h33 || b_rd1 !== 32'h33 || b_rd2 !== 32'h33) begin
      fails++; $display("FAIL byp_wr0 got a=%h b=%h want 33", a_rd1, b_rd1);
    end
    tests++;
    if (a_rd0 !== 64'h1234 || b_rd0 !== 32'h1234) begin
      fails++; $display("FAIL byp_other_port got a=%h b=%h want 1234", a_rd0, b_rd0);
    end
    tick(); idle();
  endtask

  task automatic test_scoreboard();
    idle();
    iss_en = 1; iss_rd = 12;
    ra0 = 12; ra1 = 0;
    #1;
    tests++;
    if (a_if.rd_pend[0] !== 1'b0 || b_if.rd_pend[0] !== 1'b0) begin
      fails++; $display("FAIL sb_pre_edge got a=%b b=%b want 0", a_if.rd_pend[0], b_if.rd_pend[0]);
    end
    tick(); idle();
    #1;
    tests++;
    if (a_if.rd_pend[0] !== 1'b1 || b_if.rd_pend[0] !== 1'b1) begin
      fails++; $display("FAIL sb_set got a=%b b=%b want 1", a_if.rd_pend[0], b_if.rd_pend[0]);
    end
    wr1_en = 1; wr1_addr = 12; wr1_data = 64'h55;
    #1;
    tests++;
    if (a_if.rd_pend[0] !== 1'b0 || b_if.rd_pend[0] !== 1'b0 ||
        a_rd0 !== 64'h55 || b_rd0 !== 32'h55) begin
      fails++; $display("FAIL sb_fwd got pend a=%b b=%b data a=%h b=%h want 0 0 55 55",
                        a_if.rd_pend[0], b_if.rd_pend[0], a_rd0, b_rd0);
    end
    tick(); idle();
    #1;
    tests++;
    if (a_if.rd_pend[0] !== 1'b0 || b_if.rd_pend[0] !== 1'b0) begin
      fails++; $display("FAIL sb_clear got a=%b b=%b want 0", a_if.rd_pend[0], b_if.rd_pend[0]);
    end
    iss_en = 1; iss_rd = 12;
    wr0_en = 1; wr0_addr = 12; wr0_data = 64'h66;
    tick(); idle();
    #1;
    tests++;
    if (a_if.rd_pend[0] !== 1'b1 || b_if.rd_pend[0] !== 1'b1 ||
        a_rd0 !== 64'h66 || b_rd0 !== 32'h66) begin
      fails++; $display("FAIL sb_set_wins got pend a=%b b=%b data a=%h b=%h want 1 1 66 66",
                        a_if.rd_pend[0], b_if.rd_pend[0], a_rd0, b_rd0);
    end
    iss_en = 1; iss_rd = 0;
    tick(); idle();
    ra0 = 0;
    #1;
    tests++;
    if (a_if.rd_pend[0] !== 1'b0 || b_if.rd_pend[0] !== 1'b0) begin
      fails++; $display("FAIL sb_x0 got a=%b b=%b want 0", a_if.rd_pend[0], b_if.rd_pend[0]);
    end
  endtask

  task automatic test_mid_sweep_reset();
    int first_a = 0, first_b = 0, bad = 0;
    idle();
    rst_n = 0; tick(); rst_n = 1;
    repeat (10) tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    ra0 = 3; ra1 = 4;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (a_init && first_a == 0) first_a = n;
      if (b_init && first_b == 0) first_b = n;
      wr0_en = (n >= 5 && n <= 13); wr0_addr = 3; wr0_data = 64'h77;
      wr1_en = (n >= 5 && n <= 13); wr1_addr = 4; wr1_data = 64'h88;
      iss_en = (n >= 5 && n <= 13); iss_rd = 3;
      #1;
      if (!a_init && (a_if.rd_data !== '0 || a_if.rd_pend !== '0)) bad++;
      if (!b_init && (b_if.rd_data !== '0 || b_if.rd_pend !== '0)) bad++;
    end
    idle();
    #1;
    tests++;
    if (first_a !== 31 || first_b !== 15) begin
      fails++; $display("FAIL midrst_len got a=%0d b=%0d want 31/15", first_a, first_b);
    end
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL midrst_clear_outputs nonzero cycles=%0d want 0", bad);
    end
    tests++;
    if (a_rd0 !== 64'd0 || a_rd1 !== 64'd0 || b_rd0 !== 32'd0 || b_rd1 !== 32'd0) begin
      fails++; $display("FAIL midrst_writes_ignored got a=%h/%h b=%h/%h want 0",
                        a_rd0, a_rd1, b_rd0, b_rd1);
    end
    tests++;
    if (a_if.rd_pend !== 2'b00 || b_if.rd_pend !== 3'b000) begin
      fails++; $display("FAIL midrst_iss_ignored got a=%b b=%b want 0", a_if.rd_pend, b_if.rd_pend);
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_mid_sweep_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
